// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// Holds the receiver state encoding, the bit-timing helpers and the frame width.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Last cycle index of one bit period.
  function automatic int calc_cnt_max(input int clk_freq, input int baud_rate);
    return (clk_freq / baud_rate) - 1;
  endfunction

  // Offset from the start-bit edge to the middle of the bit.
  function automatic int calc_half_cnt(input int clk_freq, input int baud_rate);
    return calc_cnt_max(clk_freq, baud_rate) / 2;
  endfunction

  // Two-out-of-three vote.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bundle from the UART receiver to its consumer.
// The receiver drives it through the master modport and the consumer reads it
// through the slave modport.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport master (output rx_data, output rx_valid, output rx_frame_err, output rx_busy);
  modport slave  (input  rx_data, input  rx_valid, input  rx_frame_err, input  rx_busy);

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous RX pin into the clk domain.
// rx_s is the two-flop synchronized line. sample is the value used at the
// mid-bit sample points: rx_s itself, or, when UART_RX_MAJORITY_EN is defined,
// the majority of the current rx_s and its two previous values.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic uart_rx_pin,
  output logic rx_s,
  output logic sample
);

  logic meta_r;
  logic sync_r;

  // Two-flop synchronizer, both stages reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= uart_rx_pin;
      sync_r <= meta_r;
    end
  end

  assign rx_s = sync_r;

`ifdef UART_RX_MAJORITY_EN
  // The three-value window is {hist_r, rx_s}: the current value is voted
  // together with the two before it, so a one-cycle glitch exactly at the
  // sample point is outvoted.
  logic [1:0] hist_r;

  // History of the synchronized line, shifted every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], sync_r};
    end
  end

  assign sample = majority3({hist_r, sync_r});
`else
  assign sample = sync_r;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// Samples each bit at mid-period, delivers bytes with a one-cycle rx_valid
// strobe and flags low stop bits with a one-cycle rx_frame_err strobe.
// Optional build macro: UART_RX_MAJORITY_EN (3-tap majority vote at the
// sample points, see uart_rx_sync).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_pin,
  uart_rx_if.master   rx_if
);

  localparam int CNT_MAX  = calc_cnt_max(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

  // Bit periods shorter than this leave no room for the mid-bit sample.
  if (CNT_MAX < 4) begin : g_cfg_check
    $error("uart_rx: CLK_FREQ/BAUD_RATE too small, CNT_MAX must be >= 4");
  end

  logic rx_s;
  logic sample;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_pin (uart_rx_pin),
    .rx_s        (rx_s),
    .sample      (sample)
  );

  rx_state_e            state_r,   state_nxt;
  logic [CNT_W-1:0]     cnt_r,     cnt_nxt;
  logic [3:0]           bit_idx_r, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_r,   shift_nxt;
  logic [DATA_BITS-1:0] data_r,    data_nxt;
  logic                 valid_r,   valid_nxt;
  logic                 ferr_r,    ferr_nxt;
  logic                 busy_r;

  // Next-state, counters, shift register and output strobes.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    bit_idx_nxt = bit_idx_r;
    shift_nxt   = shift_r;
    data_nxt    = data_r;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_nxt     = CNT_ZERO;
        bit_idx_nxt = 4'd0;
        // Edge detection uses the raw synchronized line, never the vote.
        if (!rx_s) begin
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end

      START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_nxt     = CNT_ZERO;
          bit_idx_nxt = 4'd0;
          // A line that is high again at mid start bit was a glitch.
          if (!sample) begin
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt                  = CNT_ZERO;
          shift_nxt[bit_idx_r[2:0]] = sample;
          bit_idx_nxt              = bit_idx_r + 4'd1;
          if (bit_idx_r == LAST_BIT) begin
            state_nxt = STOP;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt = CNT_ZERO;
          if (sample) begin
            data_nxt  = shift_r;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end

      BREAK: begin
        // Hold off until the line is released so a held-low line cannot
        // start a stream of bogus frames.
        cnt_nxt = CNT_ZERO;
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BREAK;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = CNT_ZERO;
        bit_idx_nxt = 4'd0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 4'd0;
      shift_r   <= '0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      bit_idx_r <= bit_idx_nxt;
      shift_r   <= shift_nxt;
      data_r    <= data_nxt;
      valid_r   <= valid_nxt;
      ferr_r    <= ferr_nxt;
      busy_r    <= (state_nxt != IDLE);
    end
  end

  assign rx_if.rx_data      = data_r;
  assign rx_if.rx_valid     = valid_r;
  assign rx_if.rx_frame_err = ferr_r;
  assign rx_if.rx_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLK_FREQ=160, BAUD_RATE=10
// (16 clocks per bit, mid-bit at clock 8 of each bit).
// Expected bytes are queued as frames are driven and popped on rx_valid.
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b1;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLK_FREQ  (160),
    .BAUD_RATE (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_pin (pin),
    .rx_if       (rx_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] last_good  = 8'h00;
  int         n_valid    = 0;
  int         n_ferr     = 0;
  int         exp_valid  = 0;
  int         exp_ferr   = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic       prev_busy  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on rx_valid and checks strobe rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid) begin
        n_valid++;
        check_eq("valid_ferr_excl", {31'd0, rx_if.rx_frame_err}, 32'd0);
        check_eq("valid_single", {31'd0, prev_valid}, 32'd0);
        check_eq("busy_fall", {30'd0, prev_busy, rx_if.rx_busy}, 32'd2);
        check_eq("q_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check_eq("rx_data", {24'd0, rx_if.rx_data}, {24'd0, mon_exp});
          last_good = mon_exp;
        end
      end
      if (rx_if.rx_frame_err) begin
        n_ferr++;
        check_eq("ferr_single", {31'd0, prev_ferr}, 32'd0);
        check_eq("ferr_data_hold", {24'd0, rx_if.rx_data}, {24'd0, last_good});
      end
    end
    prev_valid = rx_if.rx_valid;
    prev_ferr  = rx_if.rx_frame_err;
    prev_busy  = rx_if.rx_busy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 pin = 1'b1;
    end
  endtask

  // Drives start, 8 data bits LSB first and a stop bit of level stop_v.
  // glitch inverts clock 8 (the sample point) of every data bit.
  // rst_bit >= 0 pulses rst for one cycle inside that data bit and then
  // releases the line high for the rest of the frame, so the truncated frame
  // cannot be mistaken for a new one.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input bit glitch, input int rst_bit);
    logic [9:0] bits;
    bit         aborted;
    bits    = {stop_v, d, 1'b0};
    aborted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < BIT_CLKS; j++) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (aborted) pin = 1'b1;
        else if (glitch && i >= 1 && i <= 8 && j == 8) pin = ~bits[i];
        else pin = bits[i];
        if (rst_bit >= 0 && i == rst_bit + 1 && j == 4 && !aborted) begin
          rst     = 1'b1;
          pin     = 1'b1;
          aborted = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pin = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_data", {24'd0, rx_if.rx_data}, 32'd0);
    check_eq("rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_eq("rst_ferr", {31'd0, rx_if.rx_frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
    idle(5);

    // Single nominal frame.
    exp_q.push_back(8'hA5); exp_valid++;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(20);
    check_eq("a5_drained", exp_q.size(), 32'd0);

    // Back-to-back frames with no gap after the stop bit.
    exp_q.push_back(8'h00); exp_valid++;
    exp_q.push_back(8'hFF); exp_valid++;
    send_frame(8'h00, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    idle(20);
    check_eq("b2b_drained", exp_q.size(), 32'd0);

    // Three-clock low glitch on an idle line: START entered, then aborted.
    repeat (3) begin
      @(posedge clk);
      #1 pin = 1'b0;
    end
    @(posedge clk);
    #1 pin = 1'b1;
    @(negedge clk);
    check_eq("glitch_busy", {31'd0, rx_if.rx_busy}, 32'd1);
    idle(20);
    check_eq("glitch_idle", {31'd0, rx_if.rx_busy}, 32'd0);
    check_eq("glitch_nvalid", n_valid, exp_valid);
    check_eq("glitch_nferr", n_ferr, exp_ferr);

    // Low stop bit, line held low for 40 clocks in total, then released.
    exp_ferr++;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    repeat (24) begin
      @(posedge clk);
      #1 pin = 1'b0;
    end
    @(negedge clk);
    check_eq("break_busy", {31'd0, rx_if.rx_busy}, 32'd1);
    check_eq("break_nferr", n_ferr, exp_ferr);
    check_eq("break_nvalid", n_valid, exp_valid);
    idle(10);
    check_eq("break_release", {31'd0, rx_if.rx_busy}, 32'd0);
    check_eq("break_data", {24'd0, rx_if.rx_data}, 32'hFF);
    idle(10);

    // Reset during bit 4 of 0x5A, then a clean 0x81.
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    idle(40);
    check_eq("rst_mid_busy", {31'd0, rx_if.rx_busy}, 32'd0);
    check_eq("rst_mid_nvalid", n_valid, exp_valid);
    exp_q.push_back(8'h81); exp_valid++;
    send_frame(8'h81, 1'b1, 1'b0, -1);
    idle(20);
    check_eq("r81_data", {24'd0, rx_if.rx_data}, 32'h81);

    // 0x55 with a one-clock inversion at every data sample point.
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'h55);
`else
    exp_q.push_back(8'hAA);
`endif
    exp_valid++;
    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle(20);

    check_eq("final_nvalid", n_valid, exp_valid);
    check_eq("final_nferr", n_ferr, exp_ferr);
    check_eq("final_q_empty", exp_q.size(), 32'd0);
    check_eq("final_busy", {31'd0, rx_if.rx_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
